gelato_warp_fetch_unit: RTL and testbench
=========================================

Name: gelato_warp_fetch_unit

Overview:
- Per-warp consumer of the split table's select-PC interface and producer of its update-PC interface.
- Takes the split-table entry the table selects, marks it stalled, fetches one instruction from the I-cache, and hands it to decode/issue with its thread mask.
- After issue it returns the next PC to the split table and reactivates the entry, or keeps the entry stalled on control flow until the branch unit resumes it.

Parameters:
PC_WIDTH, 32, width of PC and I-cache address
INST_WIDTH, 32, instruction width
THREAD_NUM, 32, threads per warp (thread-mask width)
SPLIT_TABLE_NUM, 8, split-table entries; ST_W = $clog2(SPLIT_TABLE_NUM)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rdy  in  1  global enable; 0 freezes all state
sel_valid  in  1  selected entry is valid and active
sel_pc  in  PC_WIDTH  PC of selected entry
sel_table_num  in  ST_W  index of selected entry
upd_valid  out  1  one-cycle update pulse to split table
upd_table_num  out  ST_W  entry being updated; held between pulses
upd_pc  out  PC_WIDTH  new current_pc for entry
upd_stall  out  1  1 = deactivate entry, 0 = activate
upd_thread_mask  in  THREAD_NUM  mask of entry upd_table_num (combinational from table)
ic_req_valid  out  1  I-cache request
ic_req_ready  in  1  I-cache accepts request
ic_req_addr  out  PC_WIDTH  fetch address
ic_rsp_valid  in  1  I-cache response (no back-pressure)
ic_rsp_inst  in  INST_WIDTH  fetched instruction
inst_valid  out  1  instruction to decode
inst_ready  in  1  decode accepts
inst_data  out  INST_WIDTH  instruction
inst_pc  out  PC_WIDTH  instruction PC
inst_thread_mask  out  THREAD_NUM  active threads
inst_table_num  out  ST_W  originating split-table entry
resume_valid  in  1  branch unit resumes an entry
resume_ready  out  1  resume accepted this cycle
resume_table_num  in  ST_W  entry to resume
resume_pc  in  PC_WIDTH  resolved target PC

Behaviour:
- All registers update only on posedge clk with rst_n=1 and rdy=1. With rdy=0 nothing changes and upd_valid is not re-pulsed.
- Reset (synchronous, rst_n=0) at any point, including mid-fetch:
  - state=IDLE.
  - All outputs 0.
  - Pending-resume buffer empty; resume_ready=1.
- A response arriving in IDLE after reset is ignored.
- FSM states: IDLE, REQ, WAIT, ISSUE.
- IDLE:
  - On sel_valid, latch pc/table_num and go to REQ.
  - Next cycle issue upd_valid=1, upd_stall=1, upd_pc=sel_pc for that entry, so the table stops reselecting it.
- REQ:
  - ic_req_valid=1, ic_req_addr=latched pc.
  - Latch upd_thread_mask (upd_table_num already equals the latched entry).
  - On ic_req_ready go to WAIT.
- WAIT: on ic_rsp_valid latch ic_rsp_inst and go to ISSUE.
- ISSUE:
  - inst_valid=1; all inst_* outputs stable until inst_ready.
  - On inst_ready go to IDLE and pulse the update:
    - Non-control-flow: upd_pc=pc+4, upd_stall=0.
    - Control flow (inst[6:0] in {1100011, 1101111, 1100111}): upd_pc=pc+4, upd_stall=1; the entry stays inactive until resumed.
- pc+4 wraps modulo 2^PC_WIDTH.
- Update latency: the pulse is registered and appears one cycle after the triggering handshake.
- Resume path:
  - Accepted in any state when the one-entry pending buffer is empty; resume_ready = buffer empty.
  - A buffered resume is sent as upd_valid=1, upd_table_num=resume_table_num, upd_pc=resume_pc, upd_stall=0 on the first cycle the FSM is not emitting its own update.
  - Own updates win on conflict; the resume is delayed by one cycle, never dropped.
  - After sending, upd_table_num reverts to the FSM's latched entry, and the buffer frees.
- At most one upd_valid pulse per cycle.
- upd_valid is never asserted two cycles in a row for the same (table_num, stall) pair unless two distinct events occurred.

Test Plan:
- Reset, then sel_valid=1, sel_pc=0x100, entry 0, ic_req_ready=1, response 2 cycles later with inst 0x00000013, inst_ready=1 -> expected sequence:
  - upd (0, 0x100, stall=1).
  - ic_req_addr=0x100.
  - inst_valid with pc 0x100 and mask 0xFFFFFFFF.
  - upd (0, 0x104, stall=0).
  - Back to IDLE.
- Fetch of branch 0x00000063 at 0x200 -> update (entry, 0x204, stall=1). Then resume entry 2 with pc 0x300 -> upd (2, 0x300, stall=0), resume_ready=1 afterwards.
- Resume presented in the same cycle the FSM issues its post-issue update -> FSM update first, resume update exactly one cycle later, resume_ready=0 for one cycle.
- ic_req_ready held 0 for 5 cycles, then inst_ready held 0 for 3 cycles -> ic_req_valid/addr and inst_* stable throughout; exactly one request and one issue.
- rdy=0 for 4 cycles while in WAIT with ic_rsp_valid held -> no state change; once rdy=1 the response is captured.
- rst_n=0 during WAIT, then a stray ic_rsp_valid in IDLE -> all outputs 0, no inst_valid, no update.
- sel_pc=0xFFFFFFFC, non-branch -> upd_pc=0x00000000.

Source files
------------

// File: rtl/gelato_warp_fetch_unit.sv
// gelato_warp_fetch_unit: per-warp fetch stage between the split table, the I-cache and decode.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   rdy             : global enable; 0 freezes every register
//   sel_*           : entry selected by the split table, taken while idle
//   upd_*           : registered one-cycle update pulses to the split table;
//                     upd_thread_mask is the table's combinational mask of upd_table_num
//   ic_req_*        : I-cache request (valid/ready)
//   ic_rsp_*        : I-cache response, no back-pressure
//   inst_*          : instruction, PC, thread mask and entry handed to decode (valid/ready)
//   resume_*        : branch unit reactivating a stalled entry, one-entry buffer
module gelato_warp_fetch_unit #(
    parameter int PC_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int THREAD_NUM = 32,
    parameter int SPLIT_TABLE_NUM = 8,
    localparam int ST_W = $clog2(SPLIT_TABLE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  sel_valid,
    input  logic [PC_WIDTH-1:0]   sel_pc,
    input  logic [ST_W-1:0]       sel_table_num,
    output logic                  upd_valid,
    output logic [ST_W-1:0]       upd_table_num,
    output logic [PC_WIDTH-1:0]   upd_pc,
    output logic                  upd_stall,
    input  logic [THREAD_NUM-1:0] upd_thread_mask,
    output logic                  ic_req_valid,
    input  logic                  ic_req_ready,
    output logic [PC_WIDTH-1:0]   ic_req_addr,
    input  logic                  ic_rsp_valid,
    input  logic [INST_WIDTH-1:0] ic_rsp_inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic [THREAD_NUM-1:0] inst_thread_mask,
    output logic [ST_W-1:0]       inst_table_num,
    input  logic                  resume_valid,
    output logic                  resume_ready,
    input  logic [ST_W-1:0]       resume_table_num,
    input  logic [PC_WIDTH-1:0]   resume_pc
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, ISSUE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [ST_W-1:0]       tn_q, tn_d;
    logic [THREAD_NUM-1:0] mask_q, mask_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  upd_valid_q, upd_valid_d;
    logic [ST_W-1:0]       upd_tn_q, upd_tn_d;
    logic [PC_WIDTH-1:0]   upd_pc_q, upd_pc_d;
    logic                  upd_stall_q, upd_stall_d;
    logic                  rbuf_valid_q, rbuf_valid_d;
    logic [ST_W-1:0]       rbuf_tn_q, rbuf_tn_d;
    logic [PC_WIDTH-1:0]   rbuf_pc_q, rbuf_pc_d;
    logic                  fsm_upd, fsm_stall, rbuf_send, is_cf;
    logic [ST_W-1:0]       fsm_tn;
    logic [PC_WIDTH-1:0]   fsm_pc;

    // branch, jal, jalr keep the entry parked until the branch unit resumes it
    assign is_cf = inst_q[6:0] == 7'b1100011 || inst_q[6:0] == 7'b1101111 || inst_q[6:0] == 7'b1100111;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tn_d      = tn_q;
        mask_d    = mask_q;
        inst_d    = inst_q;
        fsm_upd   = 1'b0;
        fsm_tn    = tn_q;
        fsm_pc    = pc_q;
        fsm_stall = 1'b1;
        case (state_q)
            IDLE: if (sel_valid) begin
                state_d = REQ;
                pc_d    = sel_pc;
                tn_d    = sel_table_num;
                fsm_upd = 1'b1;
                fsm_tn  = sel_table_num;
                fsm_pc  = sel_pc;
            end
            REQ: begin
                // a buffered resume may briefly retarget upd_table_num; only trust the mask for our entry
                mask_d  = upd_tn_q == tn_q ? upd_thread_mask : mask_q;
                state_d = ic_req_ready ? WAIT : REQ;
            end
            WAIT: if (ic_rsp_valid) begin
                inst_d  = ic_rsp_inst;
                state_d = ISSUE;
            end
            default: if (inst_ready) begin
                state_d   = IDLE;
                fsm_upd   = 1'b1;
                fsm_pc    = pc_q + PC_WIDTH'(4);
                fsm_stall = is_cf;
            end
        endcase
    end

    // own updates have priority; a buffered resume goes out on the next free cycle
    always_comb begin
        rbuf_send    = rbuf_valid_q && !fsm_upd;
        upd_valid_d  = fsm_upd || rbuf_send;
        upd_tn_d     = fsm_upd ? fsm_tn : rbuf_send ? rbuf_tn_q : tn_q;
        upd_pc_d     = fsm_upd ? fsm_pc : rbuf_send ? rbuf_pc_q : upd_pc_q;
        upd_stall_d  = fsm_upd ? fsm_stall : rbuf_send ? 1'b0 : upd_stall_q;
        rbuf_valid_d = rbuf_valid_q ? !rbuf_send : resume_valid;
        rbuf_tn_d    = rbuf_valid_q ? rbuf_tn_q : resume_table_num;
        rbuf_pc_d    = rbuf_valid_q ? rbuf_pc_q : resume_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            tn_q         <= '0;
            mask_q       <= '0;
            inst_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_tn_q     <= '0;
            upd_pc_q     <= '0;
            upd_stall_q  <= 1'b0;
            rbuf_valid_q <= 1'b0;
            rbuf_tn_q    <= '0;
            rbuf_pc_q    <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tn_q         <= tn_d;
            mask_q       <= mask_d;
            inst_q       <= inst_d;
            upd_valid_q  <= upd_valid_d;
            upd_tn_q     <= upd_tn_d;
            upd_pc_q     <= upd_pc_d;
            upd_stall_q  <= upd_stall_d;
            rbuf_valid_q <= rbuf_valid_d;
            rbuf_tn_q    <= rbuf_tn_d;
            rbuf_pc_q    <= rbuf_pc_d;
        end else begin
            // frozen: the pulse already shown must not be seen again
            upd_valid_q  <= 1'b0;
        end
    end

    assign upd_valid        = upd_valid_q;
    assign upd_table_num    = upd_tn_q;
    assign upd_pc           = upd_pc_q;
    assign upd_stall        = upd_stall_q;
    assign ic_req_valid     = state_q == REQ;
    assign ic_req_addr      = pc_q;
    assign inst_valid       = state_q == ISSUE;
    assign inst_data        = inst_q;
    assign inst_pc          = pc_q;
    assign inst_thread_mask = mask_q;
    assign inst_table_num   = tn_q;
    assign resume_ready     = !rbuf_valid_q;
endmodule

// File: tb/tb_gelato_warp_fetch_unit.sv
// tb_gelato_warp_fetch_unit: scoreboard bench for the warp fetch unit.
module tb_gelato_warp_fetch_unit;
    localparam int PW = 32, IW = 32, TW = 32, STN = 8, SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, rdy = 1'b1;
    logic sel_valid = 1'b0;
    logic [PW-1:0] sel_pc = '0;
    logic [SW-1:0] sel_table_num = '0;
    logic upd_valid, upd_stall;
    logic [SW-1:0] upd_table_num;
    logic [PW-1:0] upd_pc;
    logic [TW-1:0] upd_thread_mask;
    logic ic_req_valid, ic_req_ready = 1'b0;
    logic [PW-1:0] ic_req_addr;
    logic ic_rsp_valid = 1'b0;
    logic [IW-1:0] ic_rsp_inst = '0;
    logic inst_valid, inst_ready = 1'b0;
    logic [IW-1:0] inst_data;
    logic [PW-1:0] inst_pc;
    logic [TW-1:0] inst_thread_mask;
    logic [SW-1:0] inst_table_num;
    logic resume_valid = 1'b0, resume_ready;
    logic [SW-1:0] resume_table_num = '0;
    logic [PW-1:0] resume_pc = '0;

    logic [TW-1:0] mask_tbl [STN];
    assign upd_thread_mask = mask_tbl[upd_table_num];

    gelato_warp_fetch_unit #(.PC_WIDTH(PW), .INST_WIDTH(IW), .THREAD_NUM(TW), .SPLIT_TABLE_NUM(STN)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .sel_valid(sel_valid), .sel_pc(sel_pc), .sel_table_num(sel_table_num),
        .upd_valid(upd_valid), .upd_table_num(upd_table_num), .upd_pc(upd_pc), .upd_stall(upd_stall),
        .upd_thread_mask(upd_thread_mask),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_inst(ic_rsp_inst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_thread_mask(inst_thread_mask), .inst_table_num(inst_table_num),
        .resume_valid(resume_valid), .resume_ready(resume_ready),
        .resume_table_num(resume_table_num), .resume_pc(resume_pc)
    );

    typedef struct packed { logic [SW-1:0] tn; logic [PW-1:0] pc; logic stall; } upd_t;
    typedef struct packed { logic [IW-1:0] data; logic [PW-1:0] pc; logic [TW-1:0] mask; logic [SW-1:0] tn; } inst_t;

    upd_t upd_exp[$];
    logic [PW-1:0] addr_exp[$];
    inst_t inst_exp[$];
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_cf(input logic [IW-1:0] i);
        logic [6:0] op;
        op = i[6:0];
        return op == 7'h63 || op == 7'h6f || op == 7'h67;
    endfunction

    // waits for the DUT side of a handshake whose initiator the caller has already raised
    task automatic hs_loop(input int k, input string nm);
        bit hs;
        hs = 1'b0;
        for (int n = 0; n < 40 && !hs; n++) begin
            @(negedge clk);
            hs = k == 0 ? ic_req_valid : k == 1 ? resume_ready : inst_valid;
            step();
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no handshake within 40 cycles", nm);
        end
    endtask

    // monitor: pops expectations as the DUT presents outputs, plus hold-stability checks
    upd_t m_upd;
    inst_t m_inst, p_inst;
    logic [PW-1:0] p_addr;
    bit p_req = 1'b0, p_iss = 1'b0;
    always @(negedge clk) begin
        if (upd_valid) begin
            if (upd_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_extra: got tn=%0d pc=%h stall=%0b, none expected", upd_table_num, upd_pc, upd_stall);
            end else begin
                m_upd = upd_exp.pop_front();
                chk("upd", {upd_table_num, upd_pc, upd_stall}, m_upd);
            end
        end
        if (rst_n && p_req) chk("req_hold", {ic_req_valid, ic_req_addr}, {1'b1, p_addr});
        if (rst_n && p_iss) chk("inst_hold", {inst_valid, inst_data, inst_pc, inst_thread_mask, inst_table_num}, {1'b1, p_inst});
        if (rst_n && rdy && ic_req_valid && ic_req_ready) begin
            if (addr_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_extra: got addr=%h, none expected", ic_req_addr);
            end else chk("req_addr", ic_req_addr, addr_exp.pop_front());
        end
        if (rst_n && rdy && inst_valid && inst_ready) begin
            if (inst_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst_extra: got pc=%h data=%h, none expected", inst_pc, inst_data);
            end else begin
                m_inst = inst_exp.pop_front();
                chk("inst", {inst_data, inst_pc, inst_thread_mask, inst_table_num}, m_inst);
            end
        end
        p_req  = rst_n && ic_req_valid && !(ic_req_ready && rdy);
        p_addr = ic_req_addr;
        p_iss  = rst_n && inst_valid && !(inst_ready && rdy);
        p_inst = {inst_data, inst_pc, inst_thread_mask, inst_table_num};
    end

    task automatic chk_reset_outputs(input string nm);
        @(negedge clk);
        chk({nm, "_upd"}, {upd_valid, upd_table_num, upd_pc, upd_stall}, '0);
        chk({nm, "_req"}, {ic_req_valid, ic_req_addr}, '0);
        chk({nm, "_inst"}, {inst_valid, inst_data, inst_pc, inst_thread_mask, inst_table_num}, '0);
        chk({nm, "_resume_ready"}, resume_ready, 1);
    endtask

    // one complete fetch; rmode 1 = resume while waiting for the I-cache, 2 = resume with the issue handshake
    task automatic fetch(input logic [SW-1:0] tn, input logic [PW-1:0] pc, input logic [IW-1:0] ins,
                         input int req_dly, input int rsp_dly, input int iss_dly, input int rmode,
                         input logic [SW-1:0] rtn, input logic [PW-1:0] rpc, input bit rdy_gap);
        upd_exp.push_back({tn, pc, 1'b1});
        addr_exp.push_back(pc);
        inst_exp.push_back({ins, pc, mask_tbl[tn], tn});
        sel_valid = 1'b1;
        sel_pc = pc;
        sel_table_num = tn;
        step();
        sel_valid = 1'b0;
        repeat (req_dly) step();
        ic_req_ready = 1'b1;
        hs_loop(0, "req");
        ic_req_ready = 1'b0;
        if (rmode == 1) begin
            upd_exp.push_back({rtn, rpc, 1'b0});
            resume_valid = 1'b1;
            resume_table_num = rtn;
            resume_pc = rpc;
            hs_loop(1, "resume_wait");
            resume_valid = 1'b0;
        end
        repeat (rsp_dly) step();
        ic_rsp_valid = 1'b1;
        ic_rsp_inst = ins;
        if (rdy_gap) begin
            rdy = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("frozen_wait", {inst_valid, ic_req_valid, upd_valid}, 0);
                step();
            end
            rdy = 1'b1;
        end
        step();
        ic_rsp_valid = 1'b0;
        ic_rsp_inst = $urandom;
        repeat (iss_dly) step();
        upd_exp.push_back({tn, pc + 32'd4, is_cf(ins)});
        inst_ready = 1'b1;
        if (rmode == 2) begin
            upd_exp.push_back({rtn, rpc, 1'b0});
            resume_valid = 1'b1;
            resume_table_num = rtn;
            resume_pc = rpc;
        end
        hs_loop(2, "issue");
        inst_ready = 1'b0;
        resume_valid = 1'b0;
        if (rmode == 2) begin
            @(negedge clk);
            chk("conf_fsm_first", {upd_valid, upd_table_num, upd_pc, upd_stall}, {1'b1, tn, pc + 32'd4, is_cf(ins)});
            chk("conf_rr_low", resume_ready, 0);
            step();
            @(negedge clk);
            chk("conf_resume_next", {upd_valid, upd_table_num, upd_pc, upd_stall}, {1'b1, rtn, rpc, 1'b0});
            chk("conf_rr_back", resume_ready, 1);
            step();
        end
        repeat (3) step();
    endtask

    task automatic resume(input logic [SW-1:0] rtn, input logic [PW-1:0] rpc);
        upd_exp.push_back({rtn, rpc, 1'b0});
        resume_valid = 1'b1;
        resume_table_num = rtn;
        resume_pc = rpc;
        hs_loop(1, "resume");
        resume_valid = 1'b0;
        @(negedge clk);
        chk("resume_rr_busy", resume_ready, 0);
        step();
        @(negedge clk);
        chk("resume_sent", {upd_valid, upd_table_num, upd_pc, upd_stall}, {1'b1, rtn, rpc, 1'b0});
        step();
        @(negedge clk);
        chk("resume_rr_free", resume_ready, 1);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] tn, rtn;
        logic [PW-1:0] pc, rpc;
        logic [IW-1:0] ins;
        int k;
        mask_tbl[0] = 32'hFFFF_FFFF;
        for (int i = 1; i < STN; i++) mask_tbl[i] = $urandom;
        repeat (3) step();
        rst_n = 1'b1;
        chk_reset_outputs("reset");

        fetch(3'd0, 32'h100, 32'h0000_0013, 0, 2, 0, 0, '0, '0, 1'b0);
        @(negedge clk);
        chk("idle_after_issue", {ic_req_valid, inst_valid}, 0);
        step();
        fetch(3'd2, 32'h200, 32'h0000_0063, 0, 1, 0, 0, '0, '0, 1'b0);
        resume(3'd2, 32'h300);
        fetch(3'd4, 32'h600, 32'h0000_006f, 0, 1, 0, 2, 3'd4, 32'h700, 1'b0);
        fetch(3'd1, 32'h800, 32'h0000_0033, 5, 1, 3, 0, '0, '0, 1'b0);
        fetch(3'd3, 32'h500, 32'h0000_0033, 0, 0, 0, 0, '0, '0, 1'b1);
        fetch(3'd6, 32'hFFFF_FFFC, 32'h0000_0013, 0, 1, 0, 0, '0, '0, 1'b0);

        upd_exp.push_back({3'd5, 32'h400, 1'b1});
        addr_exp.push_back(32'h400);
        sel_valid = 1'b1;
        sel_pc = 32'h400;
        sel_table_num = 3'd5;
        step();
        sel_valid = 1'b0;
        ic_req_ready = 1'b1;
        hs_loop(0, "rst_req");
        ic_req_ready = 1'b0;
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        chk_reset_outputs("midreset");
        step();
        ic_rsp_valid = 1'b1;
        ic_rsp_inst = 32'h0000_0013;
        step();
        ic_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stray_rsp_ignored", {inst_valid, upd_valid, ic_req_valid}, 0);
            step();
        end

        for (int t = 0; t < 40; t++) begin
            tn = SW'($urandom_range(0, STN - 1));
            rtn = SW'($urandom_range(0, STN - 1));
            pc = $urandom & ~32'h3;
            rpc = $urandom & ~32'h3;
            k = $urandom_range(0, 4);
            ins = k == 0 ? (($urandom & ~32'h7f) | 32'h63) :
                  k == 1 ? (($urandom & ~32'h7f) | 32'h6f) :
                  k == 2 ? (($urandom & ~32'h7f) | 32'h67) : $urandom;
            fetch(tn, pc, ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), rtn, rpc, 1'b0);
        end

        repeat (4) step();
        chk("drain_upd", upd_exp.size(), 0);
        chk("drain_req", addr_exp.size(), 0);
        chk("drain_inst", inst_exp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
